// File: rtl/tc_fetch_pkg.sv
// rtl/tc_fetch_pkg.sv - shared state encoding, decode offsets and halt-word helper for the fetch sequencer
//
// Purpose: types and helpers shared by the fetch sequencer files.
//   fetch_state_e : RUN / HALTED fetch states
//   LEN_MSB/LSB   : length-field bit offsets measured down from BIT_WIDTH
//   halt_word()   : all-ones pattern of a given word width
package tc_fetch_pkg;

   localparam int PC_W = 16;

   typedef enum logic [0:0] {
      RUN    = 1'b0,
      HALTED = 1'b1
   } fetch_state_e;

   // Length field is word0[BIT_WIDTH-LEN_MSB : BIT_WIDTH-LEN_LSB]
   localparam int LEN_MSB = 1;
   localparam int LEN_LSB = 2;

   localparam int HALT_MAX_W = 64;

   function automatic logic [HALT_MAX_W-1:0] halt_word(input int bw);
      logic [HALT_MAX_W-1:0] w;
      w = '0;
      for (int i = 0; i < HALT_MAX_W; i++) begin
         if (i < bw) w[i] = 1'b1;
      end
      return w;
   endfunction

endpackage

// File: rtl/tc_fetch_if.sv
// rtl/tc_fetch_if.sv - instruction handshake bus between fetch and decode
//
// Purpose: carries the queue head toward the decoder.
//   inst_valid : head entry valid           (master -> slave)
//   inst_ready : decoder accepts the head   (slave -> master)
//   inst_pc    : address of head instruction
//   inst_len   : 1..4 words
//   inst_words : {w3,w2,w1,w0}, unused words zero
interface tc_fetch_if #(
   parameter int BIT_WIDTH = 16
) ();
   logic                   inst_valid;
   logic                   inst_ready;
   logic [15:0]            inst_pc;
   logic [2:0]             inst_len;
   logic [4*BIT_WIDTH-1:0] inst_words;

   modport master (
      output inst_valid, inst_pc, inst_len, inst_words,
      input  inst_ready
   );

   modport slave (
      input  inst_valid, inst_pc, inst_len, inst_words,
      output inst_ready
   );
endinterface

// File: rtl/tc_fetch_queue.sv
// rtl/tc_fetch_queue.sv - 2-entry FIFO with flush and registered head
//
// Purpose: buffers decoded instructions between fetch and decode.
//   clk, rst   : clock, asynchronous active-high reset
//   flush      : empties the queue, overrides push and pop
//   push       : write push_data (ignored when full without a pop)
//   pop        : drop the head (ignored when empty)
//   head_data  : oldest entry, registered; zero when empty
//   head_valid : queue not empty
//   count      : occupancy 0..2
module tc_fetch_queue #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] push_data,
   output logic [DATA_W-1:0] head_data,
   output logic              head_valid,
   output logic [1:0]        count
);

   logic [DATA_W-1:0] slot0;
   logic [DATA_W-1:0] slot1;
   logic [1:0]        cnt;
   logic              do_pop;
   logic              do_push;

   assign do_pop  = pop && (cnt != 2'd0);
   assign do_push = push && ((cnt != 2'd2) || do_pop);

   // slot0 is always the head; vacated slots are zeroed so an empty
   // queue presents all-zero fields.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot0 <= '0;
         slot1 <= '0;
         cnt   <= 2'd0;
      end else if (flush) begin
         slot0 <= '0;
         slot1 <= '0;
         cnt   <= 2'd0;
      end else begin
         case ({do_push, do_pop})
            2'b01: begin
               slot0 <= slot1;
               slot1 <= '0;
               cnt   <= cnt - 2'd1;
            end
            2'b10: begin
               if (cnt == 2'd0) slot0 <= push_data;
               else             slot1 <= push_data;
               cnt <= cnt + 2'd1;
            end
            2'b11: begin
               if (cnt == 2'd1) begin
                  slot0 <= push_data;
               end else begin
                  slot0 <= slot1;
                  slot1 <= push_data;
               end
            end
            default: ;
         endcase
      end
   end

   assign head_data  = slot0;
   assign head_valid = (cnt != 2'd0);
   assign count      = cnt;

endmodule

// File: rtl/tc_fetch_sequencer.sv
// rtl/tc_fetch_sequencer.sv - PC, length decode, halt/redirect control ahead of the fetch queue
//
// Purpose: walks the program ROM, decodes instruction length from word0 and
// queues complete instructions for the decoder.
//   clk, rst           : clock, asynchronous active-high reset
//   address            : current PC, drives the ROM
//   word0..word3       : ROM words at pc..pc+3
//   redirect_valid     : load redirect_target and flush the queue
//   redirect_target    : new PC
//   halted             : fetch stopped on a halt word
//   inst_if (master)   : instruction handshake toward the decoder
module tc_fetch_sequencer
   import tc_fetch_pkg::*;
#(
   parameter int          BIT_WIDTH = 16,
   parameter logic [15:0] RESET_PC  = 16'h0000
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic [15:0]          address,
   input  logic [BIT_WIDTH-1:0] word0,
   input  logic [BIT_WIDTH-1:0] word1,
   input  logic [BIT_WIDTH-1:0] word2,
   input  logic [BIT_WIDTH-1:0] word3,
   input  logic                 redirect_valid,
   input  logic [15:0]          redirect_target,
   output logic                 halted,
   tc_fetch_if.master           inst_if
);

   localparam logic [0:0] S_RUN    = RUN;
   localparam logic [0:0] S_HALTED = HALTED;
   localparam logic [BIT_WIDTH-1:0] HALT_W = BIT_WIDTH'(halt_word(BIT_WIDTH));

   typedef struct packed {
      logic [PC_W-1:0]        pc;
      logic [2:0]             len;
      logic [4*BIT_WIDTH-1:0] words;
   } entry_t;

   localparam int ENTRY_W = $bits(entry_t);

   logic [PC_W-1:0]        pc;
   logic [0:0]             state;
   logic [2:0]             len;
   logic [4*BIT_WIDTH-1:0] words_masked;
   logic                   is_halt;
   logic                   running;
   logic                   pop;
   logic                   space;
   logic                   push;
   logic [1:0]             q_count;
   logic                   q_valid;
   entry_t                 q_head;
   entry_t                 push_entry;

   assign len     = {1'b0, word0[BIT_WIDTH-LEN_MSB : BIT_WIDTH-LEN_LSB]} + 3'd1;
   assign is_halt = (word0 == HALT_W);
   assign running = (state == S_RUN);

   always_comb begin
      words_masked = '0;
      words_masked[0 +: BIT_WIDTH] = word0;
      if (len >= 3'd2) words_masked[BIT_WIDTH   +: BIT_WIDTH] = word1;
      if (len >= 3'd3) words_masked[2*BIT_WIDTH +: BIT_WIDTH] = word2;
      if (len == 3'd4) words_masked[3*BIT_WIDTH +: BIT_WIDTH] = word3;
   end

   // A full queue still has room when its head leaves this same cycle.
   assign pop   = q_valid && inst_if.inst_ready && !redirect_valid;
   assign space = (q_count != 2'd2) || pop;
   assign push  = !redirect_valid && running && !is_halt && space;

   assign push_entry = '{pc: pc, len: len, words: words_masked};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc    <= RESET_PC;
         state <= S_RUN;
      end else if (redirect_valid) begin
         pc    <= redirect_target;
         state <= S_RUN;
      end else if (running && is_halt) begin
         state <= S_HALTED;
      end else if (push) begin
         pc <= pc + PC_W'(len);
      end
   end

   tc_fetch_queue #(
      .DATA_W(ENTRY_W)
   ) u_queue (
      .clk       (clk),
      .rst       (rst),
      .flush     (redirect_valid),
      .push      (push),
      .pop       (pop),
      .push_data (push_entry),
      .head_data (q_head),
      .head_valid(q_valid),
      .count     (q_count)
   );

   assign address            = pc;
   assign halted             = (state == S_HALTED);
   assign inst_if.inst_valid = q_valid;
   assign inst_if.inst_pc    = q_head.pc;
   assign inst_if.inst_len   = q_head.len;
   assign inst_if.inst_words = q_head.words;

endmodule

// File: tb/tb_tc_fetch_sequencer.sv
// tb/tb_tc_fetch_sequencer.sv - self-checking bench for the fetch sequencer
module tb_tc_fetch_sequencer;

   localparam logic [15:0] RESET_PC = 16'h0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] address;
   logic [15:0] word0, word1, word2, word3;
   logic        redirect_valid = 1'b0;
   logic [15:0] redirect_target = 16'h0000;
   logic        halted;
   logic        ready = 1'b0;

   logic [15:0] rom [0:65535];

   int checks = 0;
   int errors = 0;

   tc_fetch_if #(.BIT_WIDTH(16)) inst_if ();
   assign inst_if.inst_ready = ready;

   tc_fetch_sequencer #(.BIT_WIDTH(16), .RESET_PC(RESET_PC)) dut (
      .clk            (clk),
      .rst            (rst),
      .address        (address),
      .word0          (word0),
      .word1          (word1),
      .word2          (word2),
      .word3          (word3),
      .redirect_valid (redirect_valid),
      .redirect_target(redirect_target),
      .halted         (halted),
      .inst_if        (inst_if)
   );

   always #5 clk = ~clk;

   assign word0 = rom[address];
   assign word1 = rom[16'(address + 16'd1)];
   assign word2 = rom[16'(address + 16'd2)];
   assign word3 = rom[16'(address + 16'd3)];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Behavioural model: instruction stream walked from the ROM image,
   // held in a bounded queue of at most two instructions.
   typedef struct {
      logic [15:0] pc;
      logic [2:0]  len;
      logic [63:0] words;
   } ent_t;

   ent_t        mq[$];
   logic [15:0] mpc   = RESET_PC;
   bit          mhalt = 1'b0;
   ent_t        me;

   function automatic ent_t fetch_at(input logic [15:0] a);
      ent_t        e;
      logic [15:0] w;
      e.pc    = a;
      e.len   = 3'(rom[a] >> 14) + 3'd1;
      e.words = 64'd0;
      for (int i = 0; i < int'(e.len); i++) begin
         w = rom[16'(a + 16'(i))];
         e.words = e.words | (64'(w) << (16 * i));
      end
      return e;
   endfunction

   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
         mq.delete();
         mpc   = RESET_PC;
         mhalt = 1'b0;
      end else if (redirect_valid) begin
         mq.delete();
         mpc   = redirect_target;
         mhalt = 1'b0;
      end else begin
         if (mq.size() > 0 && ready) void'(mq.pop_front());
         if (!mhalt) begin
            if (rom[mpc] == 16'hFFFF) begin
               mhalt = 1'b1;
            end else if (mq.size() < 2) begin
               me = fetch_at(mpc);
               mq.push_back(me);
               mpc = mpc + 16'(me.len);
            end
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (!rst) begin
         chk("model_address", 64'(address), 64'(mpc));
         chk("model_halted", 64'(halted), 64'(mhalt));
         chk("model_valid", 64'(inst_if.inst_valid), 64'(mq.size() != 0));
         if (mq.size() != 0) begin
            chk("model_pc", 64'(inst_if.inst_pc), 64'(mq[0].pc));
            chk("model_len", 64'(inst_if.inst_len), 64'(mq[0].len));
            chk("model_words", inst_if.inst_words, mq[0].words);
         end
      end
   end

   task automatic expect_inst(input string name, input logic [15:0] pc, input logic [2:0] len,
                              input logic [63:0] words);
      chk({name, "_valid"}, 64'(inst_if.inst_valid), 64'd1);
      chk({name, "_pc"}, 64'(inst_if.inst_pc), 64'(pc));
      chk({name, "_len"}, 64'(inst_if.inst_len), 64'(len));
      chk({name, "_words"}, inst_if.inst_words, words);
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) rom[i] = 16'h0000;
      rom[0] = 16'h0001; rom[1] = 16'h4002; rom[2] = 16'h4003; rom[3] = 16'h8004;
      rom[4] = 16'h8005; rom[5] = 16'h8006; rom[6] = 16'hC007; rom[7] = 16'hC008;
      rom[8] = 16'hC009; rom[9] = 16'hC00A;
      rom[16'h0040] = 16'h4041; rom[16'h0041] = 16'h1234;
      ready = 1'b1;

      // reset state
      @(negedge clk);
      chk("rst_valid", 64'(inst_if.inst_valid), 64'd0);
      chk("rst_pc", 64'(inst_if.inst_pc), 64'd0);
      chk("rst_len", 64'(inst_if.inst_len), 64'd0);
      chk("rst_words", inst_if.inst_words, 64'd0);
      chk("rst_halted", 64'(halted), 64'd0);
      chk("rst_address", 64'(address), 64'(RESET_PC));
      rst = 1'b0;

      // streaming, one instruction per cycle
      @(negedge clk); expect_inst("s1_i0", 16'h0000, 3'd1, 64'h0000_0000_0000_0001);
      @(negedge clk); expect_inst("s1_i1", 16'h0001, 3'd2, 64'h0000_0000_4003_4002);
      @(negedge clk); expect_inst("s1_i2", 16'h0003, 3'd3, 64'h0000_8006_8005_8004);
      @(negedge clk); expect_inst("s1_i3", 16'h0006, 3'd4, 64'hC00A_C009_C008_C007);
      @(negedge clk); expect_inst("s1_i4", 16'h000A, 3'd1, 64'h0000_0000_0000_0000);

      // consumer stall from reset
      #2 rst = 1'b1; ready = 1'b0;
      @(negedge clk); rst = 1'b0;
      repeat (5) @(negedge clk);
      chk("stall_address", 64'(address), 64'h0003);
      expect_inst("stall_head", 16'h0000, 3'd1, 64'h0000_0000_0000_0001);
      ready = 1'b1;
      @(negedge clk); chk("drain_pc1", 64'(inst_if.inst_pc), 64'h0001);
      @(negedge clk); chk("drain_pc3", 64'(inst_if.inst_pc), 64'h0003);
      @(negedge clk); chk("drain_pc6", 64'(inst_if.inst_pc), 64'h0006);

      // redirect against a full queue with a pop in flight
      ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("pre_redir_valid", 64'(inst_if.inst_valid), 64'd1);
      ready = 1'b1; redirect_valid = 1'b1; redirect_target = 16'h0040;
      @(negedge clk);
      chk("redir_flush_valid", 64'(inst_if.inst_valid), 64'd0);
      chk("redir_address", 64'(address), 64'h0040);
      redirect_valid = 1'b0;
      @(negedge clk); expect_inst("redir_target", 16'h0040, 3'd2, 64'h0000_0000_1234_4041);

      // halt word at PC 5
      #2 rst = 1'b1;
      for (int i = 0; i < 5; i++) rom[i] = 16'h0000;
      rom[5] = 16'hFFFF;
      ready = 1'b1;
      @(negedge clk); rst = 1'b0;
      repeat (8) @(negedge clk);
      chk("halt_halted", 64'(halted), 64'd1);
      chk("halt_address", 64'(address), 64'h0005);
      chk("halt_drained", 64'(inst_if.inst_valid), 64'd0);
      redirect_valid = 1'b1; redirect_target = 16'h0000;
      @(negedge clk);
      chk("unhalt_halted", 64'(halted), 64'd0);
      chk("unhalt_address", 64'(address), 64'h0000);
      redirect_valid = 1'b0;
      @(negedge clk); expect_inst("unhalt_i0", 16'h0000, 3'd1, 64'h0000_0000_0000_0000);

      // 4-word instruction straddling the top of the address space
      rom[16'hFFFE] = 16'hC000; rom[16'hFFFF] = 16'h0011;
      rom[0] = 16'h0022; rom[1] = 16'h0033; rom[2] = 16'h0044;
      redirect_valid = 1'b1; redirect_target = 16'hFFFE;
      @(negedge clk); redirect_valid = 1'b0;
      @(negedge clk); expect_inst("wrap_i0", 16'hFFFE, 3'd4, 64'h0033_0022_0011_C000);
      @(negedge clk); expect_inst("wrap_i1", 16'h0002, 3'd1, 64'h0000_0000_0000_0044);

      // asynchronous reset with entries queued
      ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("pre_arst_valid", 64'(inst_if.inst_valid), 64'd1);
      #2 rst = 1'b1;
      #1;
      chk("arst_valid", 64'(inst_if.inst_valid), 64'd0);
      chk("arst_address", 64'(address), 64'(RESET_PC));
      chk("arst_halted", 64'(halted), 64'd0);
      @(negedge clk); rst = 1'b0;
      @(negedge clk); expect_inst("post_arst", 16'h0000, 3'd1, 64'h0000_0000_0000_0022);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
